// File: rtl/tuart_tx_sched.sv
// Two-requester arbiter/sequencer feeding the tuart_tx transmitter.
// Requester 0 has priority; requester 1 is protected from starvation by scnt.
module tuart_tx_sched #(
    parameter int unsigned WORD_BITS  = 8,
    parameter int unsigned CMD_WORDS  = 4,
    parameter int unsigned STARVE_MAX = 4,
    localparam int unsigned FW        = WORD_BITS * CMD_WORDS,
    localparam int unsigned SW        = $clog2(STARVE_MAX + 1)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          hold_i,
    input  logic          req0_stb_i,
    input  logic [FW-1:0] req0_data_i,
    output logic          req0_rdy_o,
    input  logic          req1_stb_i,
    input  logic [FW-1:0] req1_data_i,
    output logic          req1_rdy_o,
    output logic          tx_stb_o,
    output logic [FW-1:0] tx_data_o,
    input  logic          tx_rdy_i,
    output logic [1:0]    grant_o,
    output logic          busy_o
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_BUSY,
        WAIT_DONE
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [SW-1:0] scnt;
    logic          arb;
    logic          win1;

    always_comb begin
        win1      = req1_stb_i && (!req0_stb_i || (scnt == SW'(STARVE_MAX)));
        // Gated by rst_i so the Mealy accept pulses stay low during reset.
        arb       = (state == IDLE) && !rst_i && !hold_i && tx_rdy_i
                    && (req0_stb_i || req1_stb_i);
        state_nxt = state;
        case (state)
            IDLE:      if (arb) state_nxt = ISSUE;
            ISSUE:     state_nxt = WAIT_BUSY;
            WAIT_BUSY: if (!tx_rdy_i) state_nxt = WAIT_DONE;
            WAIT_DONE: if (tx_rdy_i) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    assign req0_rdy_o = arb && !win1;
    assign req1_rdy_o = arb && win1;
    assign tx_stb_o   = (state == ISSUE);
    assign busy_o     = (state != IDLE);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= IDLE;
            tx_data_o <= '0;
            grant_o   <= '0;
            scnt      <= '0;
        end else begin
            state <= state_nxt;
            if (arb) begin
                tx_data_o <= win1 ? req1_data_i : req0_data_i;
                grant_o   <= win1 ? 2'b10 : 2'b01;
                if (win1 || !req1_stb_i)
                    scnt <= '0;
                else if (scnt != SW'(STARVE_MAX))
                    scnt <= scnt + SW'(1);
            end else if ((state == WAIT_DONE) && tx_rdy_i) begin
                grant_o <= '0;
            end
        end
    end

endmodule

// File: tb/tb_tuart_tx_sched.sv
// Directed bench for tuart_tx_sched with a simple tuart_tx model,
// reactive requester drivers and a frame scoreboard.
module tb_tuart_tx_sched;

    localparam int unsigned FW = 32;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          hold_i;
    logic          req0_stb_i;
    logic [FW-1:0] req0_data_i;
    logic          req0_rdy_o;
    logic          req1_stb_i;
    logic [FW-1:0] req1_data_i;
    logic          req1_rdy_o;
    logic          tx_stb_o;
    logic [FW-1:0] tx_data_o;
    logic          tx_rdy_i;
    logic [1:0]    grant_o;
    logic          busy_o;

    always #5 clk_i = ~clk_i;

    tuart_tx_sched #(
        .WORD_BITS(8),
        .CMD_WORDS(4),
        .STARVE_MAX(4)
    ) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .hold_i(hold_i),
        .req0_stb_i(req0_stb_i),
        .req0_data_i(req0_data_i),
        .req0_rdy_o(req0_rdy_o),
        .req1_stb_i(req1_stb_i),
        .req1_data_i(req1_data_i),
        .req1_rdy_o(req1_rdy_o),
        .tx_stb_o(tx_stb_o),
        .tx_data_o(tx_data_o),
        .tx_rdy_i(tx_rdy_i),
        .grant_o(grant_o),
        .busy_o(busy_o)
    );

    typedef struct packed {
        logic [1:0]    gnt;
        logic [FW-1:0] data;
    } exp_t;

    int            n_assert = 0;
    int            n_fail   = 0;
    exp_t          expq[$];
    logic [FW-1:0] q0[$];
    logic [FW-1:0] q1[$];
    logic [1:0]    glog[$];
    logic          acc0 = 1'b0;
    logic          acc1 = 1'b0;
    logic          prev_acc = 1'b0;
    int            tx_len = 5;
    logic          xoff = 1'b0;
    logic [7:0]    tx_cnt = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [1:0] gnt, input logic [FW-1:0] data);
        exp_t e;
        e.gnt  = gnt;
        e.data = data;
        expq.push_back(e);
    endtask

    function automatic logic sig(input int which);
        case (which)
            0:       return req0_rdy_o;
            1:       return req1_rdy_o;
            2:       return tx_rdy_i;
            default: return busy_o;
        endcase
    endfunction

    task automatic wait_until(input int which, input logic val, input int budget, input string tag);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk_i);
            #1;
            if (sig(which) === val) break;
        end
        check(tag, 64'(sig(which)), 64'(val));
    endtask

    task automatic wait_idle(input int budget, input string tag);
        logic done;
        done = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk_i);
            #1;
            done = (expq.size() == 0) && !busy_o && !req0_stb_i && !req1_stb_i;
            if (done) break;
        end
        check(tag, 64'(done), 64'd1);
    endtask

    // Transmitter model: rdy drops the cycle after the strobe, low for tx_len cycles.
    always @(posedge clk_i) begin
        if (tx_stb_o)
            tx_cnt <= 8'(tx_len);
        else if (tx_cnt != 0)
            tx_cnt <= tx_cnt - 8'd1;
    end
    assign tx_rdy_i = (tx_cnt == 0) && !xoff;

    // Requesters hold stb/data until an accept is seen, then present the next frame.
    always @(posedge clk_i) begin
        #1;
        if (acc0 && q0.size() > 0) void'(q0.pop_front());
        if (acc1 && q1.size() > 0) void'(q1.pop_front());
        acc0 = 1'b0;
        acc1 = 1'b0;
        req0_stb_i  = (q0.size() > 0);
        req0_data_i = (q0.size() > 0) ? q0[0] : '0;
        req1_stb_i  = (q1.size() > 0);
        req1_data_i = (q1.size() > 0) ? q1[0] : '0;
    end

    always @(negedge clk_i) begin
        exp_t e;
        #2;
        acc0 = req0_rdy_o;
        acc1 = req1_rdy_o;
        if (acc0 || acc1) check("single_rdy", 64'(acc0 & acc1), 64'd0);
        if (tx_stb_o || prev_acc) check("stb_after_accept", 64'(tx_stb_o), 64'(prev_acc));
        prev_acc = acc0 | acc1;
        if (tx_stb_o) begin
            check("sb_nonempty", 64'(expq.size() != 0), 64'd1);
            if (expq.size() != 0) begin
                e = expq.pop_front();
                check("tx_data", 64'(tx_data_o), 64'(e.data));
                check("grant", 64'(grant_o), 64'(e.gnt));
                glog.push_back(grant_o);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int            ev;
        int            a;
        int            b;
        logic [23:0]   order;
        rst_i       = 1'b1;
        hold_i      = 1'b0;
        req0_stb_i  = 1'b0;
        req0_data_i = '0;
        req1_stb_i  = 1'b0;
        req1_data_i = '0;

        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        check("reset_ctrl", 64'({tx_stb_o, busy_o, req0_rdy_o, req1_rdy_o, grant_o}), 64'd0);
        check("reset_data", 64'(tx_data_o), 64'd0);

        // Single req0 frame with a long transmitter busy period.
        tx_len = 40;
        q0.push_back(32'hDEADBEEF);
        push_exp(2'b01, 32'hDEADBEEF);
        wait_until(0, 1'b1, 10, "t2_accept");
        @(negedge clk_i);
        #1;
        check("t2_stb", 64'(tx_stb_o), 64'd1);
        check("t2_data", 64'(tx_data_o), 64'hDEADBEEF);
        wait_until(2, 1'b0, 5, "t2_tx_busy");
        wait_until(2, 1'b1, 60, "t2_tx_done");
        check("t2_busy_hold", 64'(busy_o), 64'd1);
        @(negedge clk_i);
        #1;
        check("t2_busy_clr", 64'(busy_o), 64'd0);
        check("t2_grant_clr", 64'(grant_o), 64'd0);
        check("t2_data_kept", 64'(tx_data_o), 64'hDEADBEEF);

        // Reset while in WAIT_DONE, then a req1 frame must go through.
        q0.push_back(32'h12345678);
        push_exp(2'b01, 32'h12345678);
        wait_until(2, 1'b0, 10, "rst_tx_busy");
        @(negedge clk_i);
        #1;
        check("rst_pre_busy", 64'(busy_o), 64'd1);
        rst_i = 1'b1;
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        check("rst_mid_ctrl", 64'({tx_stb_o, busy_o, req0_rdy_o, req1_rdy_o, grant_o}), 64'd0);
        check("rst_mid_data", 64'(tx_data_o), 64'd0);
        tx_len = 5;
        q1.push_back(32'hCAFEF00D);
        push_exp(2'b10, 32'hCAFEF00D);
        wait_idle(200, "rst_recover");

        // Both requesters in the same cycle.
        glog.delete();
        q0.push_back(32'h11111111);
        q1.push_back(32'h22222222);
        push_exp(2'b01, 32'h11111111);
        push_exp(2'b10, 32'h22222222);
        wait_idle(100, "t3_done");
        check("t3_count", 64'(glog.size()), 64'd2);
        if (glog.size() == 2) check("t3_order", 64'({glog[0], glog[1]}), 64'b0110);

        // Starvation: req1 must win after four consecutive req0 grants.
        glog.delete();
        for (int k = 0; k < 10; k++) q0.push_back(32'hA0000000 + k);
        for (int k = 0; k < 2; k++) q1.push_back(32'hB0000000 + k);
        a = 0;
        b = 0;
        for (int i = 0; i < 12; i++) begin
            if (i == 4 || i == 9) begin
                push_exp(2'b10, 32'hB0000000 + b);
                b++;
            end else begin
                push_exp(2'b01, 32'hA0000000 + a);
                a++;
            end
        end
        wait_idle(1000, "t4_done");
        check("t4_count", 64'(glog.size()), 64'd12);
        order = '0;
        for (int i = 0; i < 12 && i < glog.size(); i++) order = {order[21:0], glog[i]};
        check("t4_order", 64'(order), 64'h559565);

        // hold_i blocks arbitration with both pending.
        hold_i = 1'b1;
        q0.push_back(32'h33333333);
        q1.push_back(32'h44444444);
        push_exp(2'b01, 32'h33333333);
        push_exp(2'b10, 32'h44444444);
        ev = 0;
        repeat (100) begin
            @(negedge clk_i);
            #1;
            if (req0_rdy_o || req1_rdy_o || tx_stb_o) ev++;
        end
        check("t5_hold_quiet", 64'(ev), 64'd0);
        hold_i = 1'b0;
        #1;
        check("t5_release", 64'(req0_rdy_o), 64'd1);
        wait_idle(200, "t5_done");

        // XOFF: tx_rdy_i low in IDLE blocks the accept.
        xoff = 1'b1;
        q1.push_back(32'h55555555);
        push_exp(2'b10, 32'h55555555);
        ev = 0;
        repeat (50) begin
            @(negedge clk_i);
            #1;
            if (req0_rdy_o || req1_rdy_o || tx_stb_o) ev++;
        end
        check("t6_xoff_quiet", 64'(ev), 64'd0);
        xoff = 1'b0;
        #1;
        check("t6_accept", 64'(req1_rdy_o), 64'd1);
        wait_idle(200, "t6_done");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
